// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry shared by the read and write sides.
package cpu_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int ZERO_REG  = 31;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/decoder_5to32.sv
// decoder_5to32: one-hot write-enable decoder built from two 4:16 halves selected by sel[4].
module decoder_5to32 (
  output logic [31:0] en_out,
  input  logic [4:0]  sel,
  input  logic        en_in
);
  logic [15:0] half;
  assign half   = 16'h1 << sel[3:0];
  assign en_out = {(en_in && sel[4]) ? half : 16'h0, (en_in && !sel[4]) ? half : 16'h0};
endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port: staged writeback into the integer register file with a forward path.
module regfile_write_port
  import cpu_pkg::reg_idx_t, cpu_pkg::NUM_REGS;
#(
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  reg_idx_t                   wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       stg_valid,
  output reg_idx_t                   stg_addr,
  output logic [DATA_W-1:0]          stg_data,
  output logic [15:0]                wr_count
);
  logic [NUM_REGS-1:0] en;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stg_valid <= 1'b0;
      stg_addr  <= '0;
      stg_data  <= '0;
    end else begin
      stg_valid <= wr_en && wr_addr != reg_idx_t'(ZERO_REG);
      if (wr_en) begin
        stg_addr <= wr_addr;
        stg_data <= wr_data;
      end
    end
  decoder_5to32 u_dec (.en_out(en), .sel(stg_addr), .en_in(stg_valid));
  // Any enable bit set means a commit to a real register this edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_count <= '0;
    else if (|en) wr_count <= wr_count + 16'd1;
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign regs_flat[r*DATA_W +: DATA_W] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (en[r]) q <= stg_data;
      assign regs_flat[r*DATA_W +: DATA_W] = q;
    end
  end
endmodule
